// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_if
// Description : Data-memory request/acknowledge bus between the MEM stage
//               (master) and a variable-latency data memory (slave).
//   req     master->slave  request, held high until ack
//   we      master->slave  1 store, 0 load; valid with req
//   addr    master->slave  word-aligned address
//   byte_en master->slave  store lane enables (4'b1111 on loads)
//   wdata   master->slave  lane-replicated store data
//   ack     slave->master  one-cycle acknowledge
//   rdata   slave->master  read word, valid with ack
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, byte_en, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, byte_en, wdata,
        output ack, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage plus MEM/WB register. Drives a
//               variable-latency data memory through a req/ack handshake,
//               aligns and extends sub-word loads, replicates store data,
//               stalls upstream while an access is outstanding and flags
//               misaligned accesses (AddrErr) and memory timeouts (BusErr).
// Ports       :
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid             EX/MEM holds a valid instruction
//   i_mem_read/write    load / store (both high = load)
//   i_mem_size          00 word, 01 half, 10 byte, 11 word
//   i_mem_signed        sign-extend sub-word loads
//   i_alu_result        effective address / ALU result
//   i_write_data        store data
//   i_pc, i_mem_to_reg, i_reg_write, i_write_reg   WB fields
//   o_stall             hold EX/MEM and earlier stages (combinational)
//   dmem                data-memory bus (master side)
//   o_valid ... o_write_reg   MEM/WB register outputs
//   o_addr_err, o_bus_err     one-cycle error pulses aligned with o_valid
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_valid,
    input  wire logic        i_mem_read,
    input  wire logic        i_mem_write,
    input  wire logic [1:0]  i_mem_size,
    input  wire logic        i_mem_signed,
    input  wire logic [31:0] i_alu_result,
    input  wire logic [31:0] i_write_data,
    input  wire logic [31:0] i_pc,
    input  wire logic [1:0]  i_mem_to_reg,
    input  wire logic        i_reg_write,
    input  wire logic [4:0]  i_write_reg,
    output logic             o_stall,
    mem_access_stage_if.master dmem,
    output logic             o_valid,
    output logic [1:0]       o_mem_to_reg,
    output logic [31:0]      o_alu_result,
    output logic [31:0]      o_read_data,
    output logic [31:0]      o_pc,
    output logic             o_reg_write,
    output logic [4:0]       o_write_reg,
    output logic             o_addr_err,
    output logic             o_bus_err
);

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic        r_req;

    // Access context latched when the request is launched
    logic        r_we;
    logic [31:0] r_daddr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_alu;
    logic [31:0] r_pc;
    logic [1:0]  r_m2r;
    logic        r_rw;
    logic [4:0]  r_wreg;

    // MEM/WB register
    logic        r_ov;
    logic [1:0]  r_om2r;
    logic [31:0] r_oalu;
    logic [31:0] r_ord;
    logic [31:0] r_opc;
    logic        r_orw;
    logic [4:0]  r_owreg;
    logic        r_oaerr;
    logic        r_oberr;

    logic        w_mem_op;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_start;
    logic        w_pass;
    logic        w_misal_go;
    logic        w_ack_done;
    logic        w_to_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    assign w_mem_op  = i_mem_read | i_mem_write;
    assign w_is_half = (i_mem_size == 2'b01);
    assign w_is_byte = (i_mem_size == 2'b10);
    assign w_timeout = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_misaligned = 1'b0;
        if (w_is_half) begin
            w_misaligned = i_alu_result[0];
        end else if (!w_is_byte) begin
            w_misaligned = (i_alu_result[1:0] != 2'b00);
        end
    end

    // Store lane enables and replicated data; loads enable every lane
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_write_data;
        if (w_is_byte) begin
            w_wdata = {4{i_write_data[7:0]}};
            if (!i_mem_read) begin
                w_be = 4'b0001 << i_alu_result[1:0];
            end
        end else if (w_is_half) begin
            w_wdata = {2{i_write_data[15:0]}};
            if (!i_mem_read) begin
                w_be = i_alu_result[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension from the acknowledged word
    // ------------------------------------------------------------------
    always_comb begin
        w_rbyte = dmem.rdata[7:0];
        case (r_off)
            2'd1:    w_rbyte = dmem.rdata[15:8];
            2'd2:    w_rbyte = dmem.rdata[23:16];
            2'd3:    w_rbyte = dmem.rdata[31:24];
            default: w_rbyte = dmem.rdata[7:0];
        endcase
        w_rhalf = r_off[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (r_size)
            2'b01:   w_load_data = {{16{r_signed & w_rhalf[15]}}, w_rhalf};
            2'b10:   w_load_data = {{24{r_signed & w_rbyte[7]}}, w_rbyte};
            default: w_load_data = dmem.rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next state, stall and action strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        o_stall      = 1'b0;
        w_start      = 1'b0;
        w_pass       = 1'b0;
        w_misal_go   = 1'b0;
        w_ack_done   = 1'b0;
        w_to_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    if (!w_mem_op) begin
                        w_pass = 1'b1;
                    end else if (w_misaligned) begin
                        w_misal_go = 1'b1;
                    end else begin
                        o_stall      = 1'b1;
                        w_start      = 1'b1;
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // An ack arriving in the timeout cycle completes normally
                if (dmem.ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_to_done    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next == S_WAIT);
            if (r_state == S_WAIT && w_state_next == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Access context capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_daddr  <= 32'd0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_off    <= 2'd0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_alu    <= 32'd0;
            r_pc     <= 32'd0;
            r_m2r    <= 2'd0;
            r_rw     <= 1'b0;
            r_wreg   <= 5'd0;
        end else if (w_start) begin
            r_we     <= i_mem_write & ~i_mem_read;
            r_daddr  <= {i_alu_result[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_off    <= i_alu_result[1:0];
            r_size   <= i_mem_size;
            r_signed <= i_mem_signed;
            r_alu    <= i_alu_result;
            r_pc     <= i_pc;
            r_m2r    <= i_mem_to_reg;
            r_rw     <= i_reg_write;
            r_wreg   <= i_write_reg;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register; data fields hold when nothing is loaded
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ov    <= 1'b0;
            r_om2r  <= 2'd0;
            r_oalu  <= 32'd0;
            r_ord   <= 32'd0;
            r_opc   <= 32'd0;
            r_orw   <= 1'b0;
            r_owreg <= 5'd0;
            r_oaerr <= 1'b0;
            r_oberr <= 1'b0;
        end else begin
            r_ov    <= 1'b0;
            r_orw   <= 1'b0;
            r_oaerr <= 1'b0;
            r_oberr <= 1'b0;
            if (w_pass || w_misal_go) begin
                r_ov    <= 1'b1;
                r_om2r  <= i_mem_to_reg;
                r_oalu  <= i_alu_result;
                r_ord   <= 32'd0;
                r_opc   <= i_pc;
                r_orw   <= i_reg_write & ~w_misal_go;
                r_owreg <= i_write_reg;
                r_oaerr <= w_misal_go;
            end else if (w_ack_done || w_to_done) begin
                r_ov    <= 1'b1;
                r_om2r  <= r_m2r;
                r_oalu  <= r_alu;
                r_ord   <= (w_ack_done && !r_we) ? w_load_data : 32'd0;
                r_opc   <= r_pc;
                r_orw   <= r_rw & w_ack_done;
                r_owreg <= r_wreg;
                r_oberr <= w_to_done;
            end
        end
    end

    assign dmem.req     = r_req;
    assign dmem.we      = r_we;
    assign dmem.addr    = r_daddr;
    assign dmem.byte_en = r_be;
    assign dmem.wdata   = r_wdata;

    assign o_valid      = r_ov;
    assign o_mem_to_reg = r_om2r;
    assign o_alu_result = r_oalu;
    assign o_read_data  = r_ord;
    assign o_pc         = r_opc;
    assign o_reg_write  = r_orw;
    assign o_write_reg  = r_owreg;
    assign o_addr_err   = r_oaerr;
    assign o_bus_err    = r_oberr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Scoreboard bench for mem_access_stage. A driver issues
//               instructions and pushes expected MEM/WB results; a memory
//               responder answers requests with planned latency/data and
//               checks bus fields; a monitor pops and compares results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic [1:0]  i_mem_size = 2'b00;
    logic        i_mem_signed = 1'b0;
    logic [31:0] i_alu_result = '0, i_write_data = '0, i_pc = '0;
    logic [1:0]  i_mem_to_reg = 2'b00;
    logic        i_reg_write = 1'b0;
    logic [4:0]  i_write_reg = 5'd0;
    logic        o_stall, o_valid, o_reg_write, o_addr_err, o_bus_err;
    logic [1:0]  o_mem_to_reg;
    logic [31:0] o_alu_result, o_read_data, o_pc;
    logic [4:0]  o_write_reg;

    mem_access_stage_if dmem ();

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_size(i_mem_size), .i_mem_signed(i_mem_signed),
        .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_pc(i_pc),
        .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write), .i_write_reg(i_write_reg),
        .o_stall(o_stall), .dmem(dmem),
        .o_valid(o_valid), .o_mem_to_reg(o_mem_to_reg), .o_alu_result(o_alu_result),
        .o_read_data(o_read_data), .o_pc(o_pc), .o_reg_write(o_reg_write),
        .o_write_reg(o_write_reg), .o_addr_err(o_addr_err), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, pc, rd;
        logic [1:0]  m2r;
        logic        rw;
        logic [4:0]  wr;
        logic        aerr, berr;
    } exp_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata, addr, wdata;
        logic [3:0]  be;
        logic        we;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference load extraction: plain arithmetic on the little-endian word
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                             input logic [1:0] sz, input logic sgn);
        longint v;
        if (sz == 2'b10) begin
            v = (longint'(w) >> (8 * off)) % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (sz == 2'b01) begin
            v = (longint'(w) >> (8 * (off / 2) * 2)) % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(w);
        end
        return v[31:0];
    endfunction

    // ------------------------------------------------------------------
    // Driver: issue one instruction, push expectations, wait until accepted
    // ------------------------------------------------------------------
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [1:0] m2r, input logic rw,
                         input logic [4:0] wreg, input int dly, input logic [31:0] rdat);
        exp_t  e;
        plan_t p;
        int    off = int'(a % 4);
        bit    mem_op = rd || wr;
        bit    is_load = rd;
        bit    misal;
        bit    timed_out = (dly >= TIMEOUT);
        int    guard = 0;
        if (sz == 2'b01)      misal = (off % 2) != 0;
        else if (sz == 2'b10) misal = 1'b0;
        else                  misal = (off != 0);

        e.alu = a; e.pc = pc; e.m2r = m2r; e.wr = wreg;
        e.rd = 32'd0; e.rw = rw; e.aerr = 1'b0; e.berr = 1'b0;
        if (mem_op && misal) begin
            e.rw = 1'b0; e.aerr = 1'b1;
        end else if (mem_op) begin
            p.delay = dly; p.rdata = rdat; p.addr = a - off; p.we = !is_load;
            if (sz == 2'b10) begin
                p.wdata = (wd % 256) * 32'h0101_0101;
                p.be    = is_load ? 4'hF : 4'(1 << off);
            end else if (sz == 2'b01) begin
                p.wdata = (wd % 65536) * 32'h0001_0001;
                p.be    = is_load ? 4'hF : 4'(3 << off);
            end else begin
                p.wdata = wd; p.be = 4'hF;
            end
            plan_q.push_back(p);
            if (timed_out) begin
                e.rw = 1'b0; e.berr = 1'b1;
            end else if (is_load) begin
                e.rd = ref_load(rdat, off, sz, sgn);
            end
        end
        exp_q.push_back(e);

        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_mem_size = sz;
        i_mem_signed = sgn; i_alu_result = a; i_write_data = wd; i_pc = pc;
        i_mem_to_reg = m2r; i_reg_write = rw; i_write_reg = wreg;
        #1;
        chk("stall_first", {31'd0, o_stall}, {31'd0, mem_op && !misal});
        while (o_stall) begin
            @(negedge clk); #1;
            guard++;
            if (guard > 60) begin
                chk("stall_bound", 32'd1, 32'd0);
                break;
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
        i_alu_result = $urandom; i_reg_write = 1'($urandom);
    endtask

    // ------------------------------------------------------------------
    // Memory responder: answers per plan, checks bus fields and req length
    // ------------------------------------------------------------------
    initial begin : responder
        bit    active = 1'b0;
        int    cnt = 0;
        plan_t pl;
        dmem.ack = 1'b0;
        dmem.rdata = '0;
        forever begin
            @(negedge clk);
            dmem.ack = 1'b0;
            if (!rst_n) begin
                active = 1'b0;
            end else if (dmem.req) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (plan_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                        pl.delay = 0; pl.rdata = '0; pl.addr = dmem.addr;
                        pl.wdata = dmem.wdata; pl.be = dmem.byte_en; pl.we = dmem.we;
                    end else begin
                        pl = plan_q.pop_front();
                    end
                end else begin
                    cnt++;
                end
                chk("dmem_addr", dmem.addr, pl.addr);
                chk("dmem_we", {31'd0, dmem.we}, {31'd0, pl.we});
                chk("dmem_be", {28'd0, dmem.byte_en}, {28'd0, pl.be});
                if (pl.we) chk("dmem_wdata", dmem.wdata, pl.wdata);
                dmem.rdata = $urandom;
                if (cnt == pl.delay) begin
                    dmem.ack = 1'b1;
                    dmem.rdata = pl.rdata;
                end
            end else begin
                if (active) begin
                    chk("req_cycles", cnt + 1,
                        (pl.delay < TIMEOUT) ? pl.delay + 1 : TIMEOUT);
                    active = 1'b0;
                end
                // Stray acks while idle must be ignored
                dmem.ack = ($urandom_range(0, 7) == 0);
                dmem.rdata = $urandom;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare MEM/WB against the scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("alu_out", o_alu_result, e.alu);
                        chk("pc_out", o_pc, e.pc);
                        chk("read_data", o_read_data, e.rd);
                        chk("m2r_out", {30'd0, o_mem_to_reg}, {30'd0, e.m2r});
                        chk("rw_out", {31'd0, o_reg_write}, {31'd0, e.rw});
                        chk("wreg_out", {27'd0, o_write_reg}, {27'd0, e.wr});
                        chk("addr_err", {31'd0, o_addr_err}, {31'd0, e.aerr});
                        chk("bus_err", {31'd0, o_bus_err}, {31'd0, e.berr});
                    end
                end else begin
                    chk("idle_flags", {29'd0, o_reg_write, o_addr_err, o_bus_err}, 32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        int op, r, dly;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        chk("rst_outs", {26'd0, o_valid, o_reg_write, o_addr_err, o_bus_err, o_stall, dmem.req}, 32'd0);
        chk("rst_alu", o_alu_result, 32'd0);
        chk("rst_rd", o_read_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU pass-through, LB signed, SH, misaligned LW, timeout, ack at timeout
        issue(0, 0, 2'b00, 0, 32'h1234, 0, 32'h40, 2'b00, 1, 5'd3, 0, 0);
        issue(1, 0, 2'b10, 1, 32'h103, 0, 32'h44, 2'b01, 1, 5'd4, 3, 32'h80FF_0000);
        issue(0, 1, 2'b01, 0, 32'h102, 32'hAAAA_BEEF, 32'h48, 2'b00, 0, 5'd0, 1, 0);
        issue(1, 0, 2'b00, 0, 32'h101, 0, 32'h4C, 2'b01, 1, 5'd5, 0, 0);
        issue(1, 0, 2'b00, 0, 32'h200, 0, 32'h50, 2'b01, 1, 5'd6, 100, 32'hDEAD_BEEF);
        issue(1, 0, 2'b00, 0, 32'h204, 0, 32'h54, 2'b01, 1, 5'd7, TIMEOUT - 1, 32'hCAFE_F00D);
        issue(1, 1, 2'b11, 0, 32'h208, 32'h1111_2222, 32'h58, 2'b01, 1, 5'd8, 0, 32'h0BAD_CAFE);

        // Reset asserted while an access is outstanding
        plan_q.push_back('{delay: 200, rdata: 32'h0, addr: 32'h300, wdata: 32'h0, be: 4'hF, we: 1'b0});
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_mem_size = 2'b00;
        i_alu_result = 32'h300; i_reg_write = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("rst_wait", {29'd0, dmem.req, o_stall, o_valid}, 32'd0);
        repeat (2) @(negedge clk);
        plan_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        issue(1, 0, 2'b01, 0, 32'h102, 0, 32'h60, 2'b01, 1, 5'd9, 0, 32'h8001_0000);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 3);
            r  = $urandom_range(0, 9);
            if (r < 7)      dly = $urandom_range(0, 4);
            else if (r < 9) dly = $urandom_range(5, TIMEOUT - 1);
            else            dly = $urandom_range(TIMEOUT, 30);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                // Mostly aligned addresses so accesses reach memory
                a[1:0] = 2'($urandom_range(0, 3)) & (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11);
            end
            issue(op[0] | op[1] & op[0] ? 1'b1 : op[0], op[1], 2'($urandom), 1'($urandom), a,
                  $urandom, $urandom, 2'($urandom), 1'($urandom), 5'($urandom), dly, $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("plan_empty", plan_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
